// File: rtl/pipe_ctrl_unit.sv
// Control unit for the 5-stage TSC pipeline: decode, stage control registers,
// hazard/flush/freeze arbitration, forwarding selects and a retired-instruction counter.
module pipe_ctrl_unit #(
  parameter int RF_ADDR_W = 2,
  parameter bit FWD_EN    = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_valid,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func_code,
  input  logic [RF_ADDR_W-1:0] id_rs,
  input  logic [RF_ADDR_W-1:0] id_rt,
  input  logic [RF_ADDR_W-1:0] id_rd,
  input  logic                 ex_br_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic [1:0]           pc_src,
  output logic [3:0]           ex_alu_op,
  output logic                 ex_alu_src,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic                 dmem_req,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 wb_reg_write,
  output logic                 wb_mem_to_reg,
  output logic                 wb_pc_to_reg,
  output logic                 wb_wwd,
  output logic [RF_ADDR_W-1:0] wb_dst,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired_cnt
);

  typedef struct packed {
    logic                 valid;
    logic [3:0]           alu_op;
    logic                 alu_src;
    logic [RF_ADDR_W-1:0] rs;
    logic [RF_ADDR_W-1:0] rt;
    logic [RF_ADDR_W-1:0] dst;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 pc_to_reg;
    logic                 wwd;
    logic                 branch;
    logic                 jr;
    logic                 hlt;
  } idex_t;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] dst;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 pc_to_reg;
    logic                 wwd;
    logic                 hlt;
  } exmem_t;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] dst;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 pc_to_reg;
    logic                 wwd;
    logic                 hlt;
  } memwb_t;

  idex_t            dec_s, idex_r;
  exmem_t           exmem_r;
  memwb_t           memwb_r;
  logic             use_rs_s, use_rt_s, jump_s;
  logic             dmem_stall_s, redirect_s, ex_hit_s, mem_hit_s, hazard_s, hlt_block_s;
  logic             advance_s, bubble_s;
  logic             pc_write_s, ifid_write_s, ifid_flush_s;
  logic [1:0]       pc_src_s, fwd_a_s, fwd_b_s;
  logic             halted_r;
  logic [CNT_W-1:0] retired_r;

  // ID-stage decode; control bits are valid-qualified so bubbles carry no side effects
  always_comb begin
    dec_s         = '0;
    use_rs_s      = 1'b0;
    use_rt_s      = 1'b0;
    jump_s        = 1'b0;
    dec_s.rs      = id_rs;
    dec_s.rt      = id_rt;
    dec_s.alu_src = 1'b1;
    case (opcode)
      4'd0, 4'd1: begin dec_s.branch = 1'b1; use_rs_s = 1'b1; use_rt_s = 1'b1; end
      4'd2, 4'd3: begin dec_s.branch = 1'b1; use_rs_s = 1'b1; end
      4'd4: begin dec_s.reg_write = 1'b1; dec_s.dst = id_rt; use_rs_s = 1'b1; end
      4'd5: begin dec_s.reg_write = 1'b1; dec_s.dst = id_rt; dec_s.alu_op = 4'd3; use_rs_s = 1'b1; end
      4'd6: begin dec_s.reg_write = 1'b1; dec_s.dst = id_rt; dec_s.alu_op = 4'd8; end
      4'd7: begin
        dec_s.reg_write = 1'b1; dec_s.dst = id_rt; dec_s.mem_read = 1'b1;
        dec_s.mem_to_reg = 1'b1; use_rs_s = 1'b1;
      end
      4'd8: begin dec_s.mem_write = 1'b1; use_rs_s = 1'b1; use_rt_s = 1'b1; end
      4'd9: begin jump_s = 1'b1; end
      4'd10: begin
        jump_s = 1'b1; dec_s.reg_write = 1'b1; dec_s.dst = RF_ADDR_W'(2); dec_s.pc_to_reg = 1'b1;
      end
      4'd15: begin
        dec_s.alu_src = 1'b0;
        case (func_code)
          6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7: begin
            dec_s.alu_op = {1'b0, func_code[2:0]}; dec_s.reg_write = 1'b1; dec_s.dst = id_rd;
            use_rs_s = 1'b1; use_rt_s = 1'b1;
          end
          6'd25: begin dec_s.alu_op = 4'd9; dec_s.jr = 1'b1; use_rs_s = 1'b1; end
          6'd26: begin
            dec_s.alu_op = 4'd9; dec_s.jr = 1'b1; use_rs_s = 1'b1;
            dec_s.reg_write = 1'b1; dec_s.dst = RF_ADDR_W'(2); dec_s.pc_to_reg = 1'b1;
          end
          6'd28: begin dec_s.alu_op = 4'd9; dec_s.wwd = 1'b1; use_rs_s = 1'b1; end
          6'd29: begin dec_s.hlt = 1'b1; end
          default: begin dec_s.alu_op = 4'd0; end
        endcase
      end
      default: begin dec_s.alu_op = 4'd0; end
    endcase
    if (!inst_valid) begin
      dec_s    = '0;
      use_rs_s = 1'b0;
      use_rt_s = 1'b0;
      jump_s   = 1'b0;
    end else begin
      dec_s.valid = 1'b1;
    end
  end

  // Hazard detection against the instructions ahead of ID
  always_comb begin
    dmem_stall_s = (exmem_r.mem_read | exmem_r.mem_write) & ~dmem_ready;
    redirect_s   = (idex_r.branch | idex_r.jr) & ex_br_taken;
    ex_hit_s     = idex_r.reg_write & ((use_rs_s & (idex_r.dst == id_rs)) |
                                       (use_rt_s & (idex_r.dst == id_rt)));
    mem_hit_s    = exmem_r.reg_write & ((use_rs_s & (exmem_r.dst == id_rs)) |
                                        (use_rt_s & (exmem_r.dst == id_rt)));
    hlt_block_s  = dec_s.hlt | idex_r.hlt | exmem_r.hlt | memwb_r.hlt;
    if (FWD_EN) begin
      hazard_s = ex_hit_s & idex_r.mem_read;
    end else begin
      hazard_s = ex_hit_s | mem_hit_s;
    end
  end

  // Priority arbitration: dmem freeze > redirect > hazard > jump > fetch hold
  always_comb begin
    pc_write_s   = 1'b1;
    ifid_write_s = 1'b1;
    ifid_flush_s = 1'b0;
    pc_src_s     = 2'b00;
    advance_s    = 1'b1;
    bubble_s     = 1'b0;
    if (reset) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      advance_s    = 1'b0;
    end else if (dmem_stall_s) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      advance_s    = 1'b0;
    end else if (halted_r) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      bubble_s     = 1'b1;
    end else if (redirect_s) begin
      ifid_flush_s = 1'b1;
      bubble_s     = 1'b1;
      pc_src_s     = idex_r.jr ? 2'b11 : 2'b01;
    end else if (hazard_s) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      bubble_s     = 1'b1;
    end else if (jump_s) begin
      pc_src_s     = 2'b10;
      ifid_flush_s = 1'b1;
    end else if (hlt_block_s || !imem_ready) begin
      pc_write_s   = 1'b0;
      ifid_flush_s = 1'b1;
    end else begin
      bubble_s     = 1'b0;
    end
  end

  // Operand forwarding; the younger (MEM) producer wins over WB
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (FWD_EN) begin
      if (exmem_r.reg_write && (exmem_r.dst == idex_r.rs)) begin
        fwd_a_s = 2'b01;
      end else if (memwb_r.reg_write && (memwb_r.dst == idex_r.rs)) begin
        fwd_a_s = 2'b10;
      end else begin
        fwd_a_s = 2'b00;
      end
      if (exmem_r.reg_write && (exmem_r.dst == idex_r.rt)) begin
        fwd_b_s = 2'b01;
      end else if (memwb_r.reg_write && (memwb_r.dst == idex_r.rt)) begin
        fwd_b_s = 2'b10;
      end else begin
        fwd_b_s = 2'b00;
      end
    end else begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end
  end

  // Stage control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_r  <= '0;
      exmem_r <= '0;
      memwb_r <= '0;
    end else if (advance_s) begin
      idex_r             <= bubble_s ? '0 : dec_s;
      exmem_r.valid      <= idex_r.valid;
      exmem_r.dst        <= idex_r.dst;
      exmem_r.reg_write  <= idex_r.reg_write;
      exmem_r.mem_read   <= idex_r.mem_read;
      exmem_r.mem_write  <= idex_r.mem_write;
      exmem_r.mem_to_reg <= idex_r.mem_to_reg;
      exmem_r.pc_to_reg  <= idex_r.pc_to_reg;
      exmem_r.wwd        <= idex_r.wwd;
      exmem_r.hlt        <= idex_r.hlt;
      memwb_r.valid      <= exmem_r.valid;
      memwb_r.dst        <= exmem_r.dst;
      memwb_r.reg_write  <= exmem_r.reg_write;
      memwb_r.mem_to_reg <= exmem_r.mem_to_reg;
      memwb_r.pc_to_reg  <= exmem_r.pc_to_reg;
      memwb_r.wwd        <= exmem_r.wwd;
      memwb_r.hlt        <= exmem_r.hlt;
    end
  end

  // Retirement: count instructions leaving WB, latch halt when HLT leaves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_r <= '0;
      halted_r  <= 1'b0;
    end else if (advance_s && memwb_r.valid) begin
      if (retired_r != {CNT_W{1'b1}}) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (memwb_r.hlt) begin
        halted_r <= 1'b1;
      end
    end
  end

  assign pc_write      = pc_write_s;
  assign ifid_write    = ifid_write_s;
  assign ifid_flush    = ifid_flush_s;
  assign pc_src        = pc_src_s;
  assign ex_alu_op     = idex_r.alu_op;
  assign ex_alu_src    = idex_r.alu_src;
  assign fwd_a         = fwd_a_s;
  assign fwd_b         = fwd_b_s;
  assign dmem_req      = exmem_r.mem_read | exmem_r.mem_write;
  assign mem_read      = exmem_r.mem_read;
  assign mem_write     = exmem_r.mem_write;
  assign wb_reg_write  = memwb_r.reg_write;
  assign wb_mem_to_reg = memwb_r.mem_to_reg;
  assign wb_pc_to_reg  = memwb_r.pc_to_reg;
  assign wb_wwd        = memwb_r.wwd;
  assign wb_dst        = memwb_r.dst;
  assign halted        = halted_r;
  assign retired_cnt   = retired_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one forwarding instance and one non-forwarding instance
// driven from the same ID-stage stimulus.
module tb_pipe_ctrl_unit;

  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_R   = 4'd15;
  localparam logic [5:0] F_ADD  = 6'd0;
  localparam logic [5:0] F_HLT  = 6'd29;

  logic       clk, reset, inst_valid, ex_br_taken, imem_ready, dmem_ready;
  logic [3:0] opcode;
  logic [5:0] func_code;
  logic [1:0] id_rs, id_rt, id_rd;

  logic        pc_write, ifid_write, ifid_flush, ex_alu_src, dmem_req, mem_read, mem_write;
  logic        wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, wb_wwd, halted;
  logic [1:0]  pc_src, fwd_a, fwd_b, wb_dst;
  logic [3:0]  ex_alu_op;
  logic [15:0] retired_cnt;

  logic        pc_write_0, ifid_write_0, ifid_flush_0, ex_alu_src_0, dmem_req_0, mem_read_0, mem_write_0;
  logic        wb_reg_write_0, wb_mem_to_reg_0, wb_pc_to_reg_0, wb_wwd_0, halted_0;
  logic [1:0]  pc_src_0, fwd_a_0, fwd_b_0, wb_dst_0;
  logic [3:0]  ex_alu_op_0;
  logic [15:0] retired_cnt_0;

  logic [23:0] outs1, outs0;
  int checks = 0;
  int failures = 0;

  assign outs1 = {pc_write, ifid_write, ifid_flush, pc_src, ex_alu_op, ex_alu_src, fwd_a, fwd_b,
                  dmem_req, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, wb_wwd,
                  wb_dst, halted};
  assign outs0 = {pc_write_0, ifid_write_0, ifid_flush_0, pc_src_0, ex_alu_op_0, ex_alu_src_0, fwd_a_0,
                  fwd_b_0, dmem_req_0, mem_read_0, mem_write_0, wb_reg_write_0, wb_mem_to_reg_0,
                  wb_pc_to_reg_0, wb_wwd_0, wb_dst_0, halted_0};

  pipe_ctrl_unit #(.RF_ADDR_W(2), .FWD_EN(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .opcode(opcode), .func_code(func_code),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .pc_src(pc_src),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dmem_req(dmem_req), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_pc_to_reg(wb_pc_to_reg),
    .wb_wwd(wb_wwd), .wb_dst(wb_dst), .halted(halted), .retired_cnt(retired_cnt)
  );

  pipe_ctrl_unit #(.RF_ADDR_W(2), .FWD_EN(1'b0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .opcode(opcode), .func_code(func_code),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(pc_write_0), .ifid_write(ifid_write_0), .ifid_flush(ifid_flush_0), .pc_src(pc_src_0),
    .ex_alu_op(ex_alu_op_0), .ex_alu_src(ex_alu_src_0), .fwd_a(fwd_a_0), .fwd_b(fwd_b_0),
    .dmem_req(dmem_req_0), .mem_read(mem_read_0), .mem_write(mem_write_0),
    .wb_reg_write(wb_reg_write_0), .wb_mem_to_reg(wb_mem_to_reg_0), .wb_pc_to_reg(wb_pc_to_reg_0),
    .wb_wwd(wb_wwd_0), .wb_dst(wb_dst_0), .halted(halted_0), .retired_cnt(retired_cnt_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] op, input logic [5:0] fn,
                        input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd);
    inst_valid = v;
    opcode     = op;
    func_code  = fn;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    #2;
  endtask

  task automatic rst_pulse();
    reset       = 1'b1;
    inst_valid  = 1'b0;
    ex_br_taken = 1'b0;
    imem_ready  = 1'b1;
    dmem_ready  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ex_br_taken = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    set_id(1'b1, OP_JAL, 6'd0, 2'd0, 2'd0, 2'd0);
    #1;
    chk("reset_outs", 32'(outs1), 32'd0);
    chk("reset_outs_nofwd", 32'(outs0), 32'd0);
    chk("reset_cnt", 32'(retired_cnt), 32'd0);

    // load-use with forwarding: one stall cycle, then both operands from WB
    rst_pulse();
    set_id(1'b1, OP_LWD, 6'd0, 2'd0, 2'd1, 2'd0);
    chk("lu_pre_pcw", 32'(pc_write), 32'd1);
    cyc();
    set_id(1'b1, OP_R, F_ADD, 2'd1, 2'd1, 2'd2);
    chk("lu_stall_pcw", 32'(pc_write), 32'd0);
    chk("lu_stall_ifidw", 32'(ifid_write), 32'd0);
    chk("lu_ex_alu_src", 32'(ex_alu_src), 32'd1);
    cyc();
    set_id(1'b1, OP_R, F_ADD, 2'd1, 2'd1, 2'd2);
    chk("lu_one_cycle", 32'(pc_write), 32'd1);
    chk("lu_bubble_src", 32'(ex_alu_src), 32'd0);
    cyc();
    set_id(1'b0, 4'd0, 6'd0, 2'd0, 2'd0, 2'd0);
    chk("lu_fwd_a", 32'(fwd_a), 32'd2);
    chk("lu_fwd_b", 32'(fwd_b), 32'd2);
    chk("lu_wb_m2r", 32'(wb_mem_to_reg), 32'd1);
    chk("lu_wb_dst", 32'(wb_dst), 32'd1);
    cyc();

    // ALU RAW with forwarding: no stall, EX/MEM forward
    set_id(1'b1, OP_R, F_ADD, 2'd0, 2'd0, 2'd1);
    chk("lu_retired", 32'(retired_cnt), 32'd1);
    cyc();
    set_id(1'b1, OP_R, F_ADD, 2'd1, 2'd0, 2'd2);
    chk("raw_nostall", 32'(pc_write), 32'd1);
    cyc();
    set_id(1'b0, 4'd0, 6'd0, 2'd0, 2'd0, 2'd0);
    chk("raw_fwd_a", 32'(fwd_a), 32'd1);
    chk("raw_fwd_b", 32'(fwd_b), 32'd0);
    cyc();

    // no forwarding: two stall cycles, WB never stalls, selects stay 00
    rst_pulse();
    set_id(1'b1, OP_R, F_ADD, 2'd2, 2'd2, 2'd0);
    cyc();
    set_id(1'b1, OP_R, F_ADD, 2'd0, 2'd0, 2'd2);
    chk("nf_stall1", 32'(pc_write_0), 32'd0);
    cyc();
    set_id(1'b1, OP_R, F_ADD, 2'd0, 2'd0, 2'd2);
    chk("nf_stall2", 32'(pc_write_0), 32'd0);
    chk("nf_stall2_ifidw", 32'(ifid_write_0), 32'd0);
    cyc();
    set_id(1'b1, OP_R, F_ADD, 2'd0, 2'd0, 2'd2);
    chk("nf_release", 32'(pc_write_0), 32'd1);
    chk("nf_fwd_a", 32'(fwd_a_0), 32'd0);
    cyc();

    // taken BEQ: redirect, two bubbles, flushed work never retires
    rst_pulse();
    set_id(1'b1, OP_BEQ, 6'd0, 2'd0, 2'd0, 2'd0);
    cyc();
    ex_br_taken = 1'b1;
    set_id(1'b1, OP_ADI, 6'd0, 2'd0, 2'd1, 2'd0);
    chk("br_pc_src", 32'(pc_src), 32'd1);
    chk("br_flush", 32'(ifid_flush), 32'd1);
    chk("br_pcw", 32'(pc_write), 32'd1);
    cyc();
    ex_br_taken = 1'b0;
    set_id(1'b0, 4'd0, 6'd0, 2'd0, 2'd0, 2'd0);
    chk("br_pc_src_after", 32'(pc_src), 32'd0);
    chk("br_bubble1", 32'(ex_alu_src), 32'd0);
    cyc();
    set_id(1'b1, OP_ADI, 6'd0, 2'd0, 2'd3, 2'd0);
    chk("br_bubble2", 32'(ex_alu_src), 32'd0);
    cyc();
    set_id(1'b0, 4'd0, 6'd0, 2'd0, 2'd0, 2'd0);
    repeat (3) cyc();
    chk("br_retired", 32'(retired_cnt), 32'd2);

    // JAL: one-cycle flush, link to r2 at WB; fetch hold on imem not ready
    rst_pulse();
    set_id(1'b1, OP_JAL, 6'd0, 2'd0, 2'd0, 2'd0);
    chk("jal_pc_src", 32'(pc_src), 32'd2);
    chk("jal_flush", 32'(ifid_flush), 32'd1);
    cyc();
    set_id(1'b0, 4'd0, 6'd0, 2'd0, 2'd0, 2'd0);
    chk("jal_flush_once", 32'(ifid_flush), 32'd0);
    chk("jal_pc_src_after", 32'(pc_src), 32'd0);
    cyc();
    imem_ready = 1'b0;
    set_id(1'b0, 4'd0, 6'd0, 2'd0, 2'd0, 2'd0);
    chk("imem_pcw", 32'(pc_write), 32'd0);
    chk("imem_flush", 32'(ifid_flush), 32'd1);
    cyc();
    imem_ready = 1'b1;
    set_id(1'b0, 4'd0, 6'd0, 2'd0, 2'd0, 2'd0);
    chk("jal_wb_dst", 32'(wb_dst), 32'd2);
    chk("jal_wb_pc2reg", 32'(wb_pc_to_reg), 32'd1);
    chk("jal_wb_rw", 32'(wb_reg_write), 32'd1);
    cyc();

    // SWD with dmem not ready for three cycles; branch in EX must wait
    rst_pulse();
    set_id(1'b1, OP_SWD, 6'd0, 2'd0, 2'd1, 2'd0);
    cyc();
    set_id(1'b1, OP_BEQ, 6'd0, 2'd0, 2'd0, 2'd0);
    cyc();
    dmem_ready  = 1'b0;
    ex_br_taken = 1'b1;
    set_id(1'b1, OP_ADI, 6'd0, 2'd0, 2'd1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      chk("dm_req", 32'(dmem_req), 32'd1);
      chk("dm_mem_write", 32'(mem_write), 32'd1);
      chk("dm_pcw", 32'(pc_write), 32'd0);
      chk("dm_ifidw", 32'(ifid_write), 32'd0);
      chk("dm_br_waits", 32'(pc_src), 32'd0);
      cyc();
    end
    dmem_ready = 1'b1;
    #2;
    chk("dm_br_go", 32'(pc_src), 32'd1);
    chk("dm_req_last", 32'(dmem_req), 32'd1);
    chk("dm_retired0", 32'(retired_cnt), 32'd0);
    cyc();
    ex_br_taken = 1'b0;
    set_id(1'b0, 4'd0, 6'd0, 2'd0, 2'd0, 2'd0);
    chk("dm_req_done", 32'(dmem_req), 32'd0);
    cyc();
    chk("dm_retired1", 32'(retired_cnt), 32'd1);

    // five ADIs then HLT: halt latches as HLT leaves WB, six retired
    rst_pulse();
    for (int k = 0; k < 5; k++) begin
      set_id(1'b1, OP_ADI, 6'd0, 2'd0, 2'd1, 2'd0);
      cyc();
    end
    set_id(1'b1, OP_R, F_HLT, 2'd0, 2'd0, 2'd0);
    chk("hlt_id_pcw", 32'(pc_write), 32'd0);
    chk("hlt_id_flush", 32'(ifid_flush), 32'd1);
    cyc();
    set_id(1'b0, 4'd0, 6'd0, 2'd0, 2'd0, 2'd0);
    chk("hlt_ex_pcw", 32'(pc_write), 32'd0);
    cyc();
    cyc();
    chk("hlt_not_yet", 32'(halted), 32'd0);
    cyc();
    set_id(1'b1, OP_ADI, 6'd0, 2'd0, 2'd1, 2'd0);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_retired", 32'(retired_cnt), 32'd6);
    chk("hlt_no_fetch", 32'(pc_write), 32'd0);
    chk("hlt_no_ifid", 32'(ifid_write), 32'd0);
    cyc();
    cyc();
    chk("hlt_no_ex", 32'(ex_alu_src), 32'd0);
    chk("hlt_retired_hold", 32'(retired_cnt), 32'd6);

    // reset mid dmem stall clears everything at once
    rst_pulse();
    set_id(1'b1, OP_SWD, 6'd0, 2'd0, 2'd1, 2'd0);
    cyc();
    set_id(1'b0, 4'd0, 6'd0, 2'd0, 2'd0, 2'd0);
    cyc();
    dmem_ready = 1'b0;
    #2;
    chk("rs_req_before", 32'(dmem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_async_outs", 32'(outs1), 32'd0);
    chk("rs_async_cnt", 32'(retired_cnt), 32'd0);
    reset = 1'b0;
    #1;
    chk("rs_no_pending", 32'(dmem_req), 32'd0);
    chk("rs_pcw", 32'(pc_write), 32'd1);
    dmem_ready = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
